// File: rtl/uart_fifo_pkg.sv
// Shared helpers for the FIFO pointer synchronizer: Gray decode, Hamming distance and
// the legal range of synchronizer depths.
package uart_fifo_pkg;

  localparam int unsigned NUM_STAGES_MIN = 2;
  localparam int unsigned NUM_STAGES_MAX = 4;
  localparam int unsigned PTR_WIDTH_MIN  = 2;
  localparam int unsigned PTR_WIDTH_MAX  = 16;

  // Callers zero-extend narrower pointers; leading zeros do not change the low bits.
  function automatic logic [PTR_WIDTH_MAX-1:0] gray2bin(input logic [PTR_WIDTH_MAX-1:0] gray);
    logic [PTR_WIDTH_MAX-1:0] bin;
    bin[PTR_WIDTH_MAX-1] = gray[PTR_WIDTH_MAX-1];
    for (int i = PTR_WIDTH_MAX - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  function automatic int unsigned hamming(input logic [PTR_WIDTH_MAX-1:0] a,
                                          input logic [PTR_WIDTH_MAX-1:0] b);
    logic [PTR_WIDTH_MAX-1:0] diff;
    int unsigned              cnt;
    diff = a ^ b;
    cnt  = 0;
    for (int i = 0; i < PTR_WIDTH_MAX; i++) begin
      if (diff[i]) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/uart_fifo_sync_chain.sv
// Multi-flop synchronizer chain for a Gray-coded pointer crossing into this clock domain.
module uart_fifo_sync_chain #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned NUM_STAGES = 2
) (
  input  logic             i_fifo_dfsync_clk,
  input  logic             i_fifo_dfsync_rst_n,
  input  logic [WIDTH-1:0] i_sync_d,
  output logic [WIDTH-1:0] o_sync_q
);

  logic [WIDTH-1:0] stage_q [NUM_STAGES];

  always_ff @(posedge i_fifo_dfsync_clk or negedge i_fifo_dfsync_rst_n) begin
    if (!i_fifo_dfsync_rst_n) begin
      for (int k = 0; k < NUM_STAGES; k++) stage_q[k] <= '0;
    end else begin
      stage_q[0] <= i_sync_d;
      for (int k = 1; k < NUM_STAGES; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign o_sync_q = stage_q[NUM_STAGES-1];

endmodule

// File: rtl/uart_fifo_ptr_sync.sv
// Gray pointer synchronizer with registered binary output, change pulse, warm-up valid
// and a sticky flag for multi-bit (non-Gray) pointer moves.
module uart_fifo_ptr_sync
  import uart_fifo_pkg::*;
#(
  parameter int unsigned PTR_WIDTH  = 4,
  parameter int unsigned NUM_STAGES = 2
) (
  input  logic                 i_fifo_dfsync_clk,
  input  logic                 i_fifo_dfsync_rst_n,
  input  logic [PTR_WIDTH-1:0] i_fifo_dfsync_gray,
  input  logic                 i_fifo_dfsync_err_clr,
  output logic [PTR_WIDTH-1:0] o_fifo_dfsync_gray,
  output logic [PTR_WIDTH-1:0] o_fifo_dfsync_bin,
  output logic                 o_fifo_dfsync_chg,
  output logic                 o_fifo_dfsync_valid,
  output logic                 o_fifo_dfsync_err
);

  localparam int unsigned          CNT_WIDTH = $clog2(NUM_STAGES + 2);
  localparam logic [CNT_WIDTH-1:0] CNT_DONE  = CNT_WIDTH'(NUM_STAGES + 1);

  if (NUM_STAGES < NUM_STAGES_MIN || NUM_STAGES > NUM_STAGES_MAX) begin : g_bad_stages
    $error("uart_fifo_ptr_sync: NUM_STAGES must be in 2..4");
  end
  if (PTR_WIDTH < PTR_WIDTH_MIN || PTR_WIDTH > PTR_WIDTH_MAX) begin : g_bad_width
    $error("uart_fifo_ptr_sync: PTR_WIDTH must be in 2..16");
  end

  logic [PTR_WIDTH-1:0] sync_gray;
  logic [PTR_WIDTH-1:0] gray_q, gray_d;
  logic [PTR_WIDTH-1:0] bin_q, bin_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 chg_q, chg_d;
  logic                 err_q, err_d;
  logic                 valid;
  logic                 violation;

  uart_fifo_sync_chain #(
    .WIDTH      (PTR_WIDTH),
    .NUM_STAGES (NUM_STAGES)
  ) u_sync_chain (
    .i_fifo_dfsync_clk   (i_fifo_dfsync_clk),
    .i_fifo_dfsync_rst_n (i_fifo_dfsync_rst_n),
    .i_sync_d            (i_fifo_dfsync_gray),
    .o_sync_q            (sync_gray)
  );

  assign valid = (cnt_q == CNT_DONE);

  always_comb begin
    gray_d    = sync_gray;
    bin_d     = PTR_WIDTH'(gray2bin(PTR_WIDTH_MAX'(sync_gray)));
    cnt_d     = cnt_q;
    chg_d     = 1'b0;
    err_d     = err_q;
    violation = 1'b0;
    if (!valid) cnt_d = cnt_q + CNT_WIDTH'(1);
    // Before warm-up ends the output still holds its reset value, so moves are not real.
    if (valid) begin
      chg_d     = (sync_gray != gray_q);
      violation = (hamming(PTR_WIDTH_MAX'(sync_gray), PTR_WIDTH_MAX'(gray_q)) >= 2);
    end
    if (i_fifo_dfsync_err_clr) err_d = 1'b0;
    if (violation)             err_d = 1'b1;
  end

  always_ff @(posedge i_fifo_dfsync_clk or negedge i_fifo_dfsync_rst_n) begin
    if (!i_fifo_dfsync_rst_n) begin
      gray_q <= '0;
      bin_q  <= '0;
      cnt_q  <= '0;
      chg_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      gray_q <= gray_d;
      bin_q  <= bin_d;
      cnt_q  <= cnt_d;
      chg_q  <= chg_d;
      err_q  <= err_d;
    end
  end

  assign o_fifo_dfsync_gray  = gray_q;
  assign o_fifo_dfsync_bin   = bin_q;
  assign o_fifo_dfsync_chg   = chg_q;
  assign o_fifo_dfsync_valid = valid;
  assign o_fifo_dfsync_err   = err_q;

endmodule

// File: tb/tb_uart_fifo_ptr_sync.sv
// Scoreboard bench for uart_fifo_ptr_sync: directed pointer sequences with hand-computed
// outputs, plus a NUM_STAGES = 3 instance for latency and warm-up checks.
module tb_uart_fifo_ptr_sync;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] gin   = 4'b0101;
  logic [3:0] gin3  = 4'b0000;
  logic       clr   = 1'b0;

  logic [3:0] o_gray, o_bin, o_gray3, o_bin3;
  logic       o_chg, o_valid, o_err, o_chg3, o_valid3, o_err3;

  always #5 clk = ~clk;

  uart_fifo_ptr_sync #(.PTR_WIDTH(4), .NUM_STAGES(2)) dut (
    .i_fifo_dfsync_clk     (clk),
    .i_fifo_dfsync_rst_n   (rst_n),
    .i_fifo_dfsync_gray    (gin),
    .i_fifo_dfsync_err_clr (clr),
    .o_fifo_dfsync_gray    (o_gray),
    .o_fifo_dfsync_bin     (o_bin),
    .o_fifo_dfsync_chg     (o_chg),
    .o_fifo_dfsync_valid   (o_valid),
    .o_fifo_dfsync_err     (o_err)
  );

  uart_fifo_ptr_sync #(.PTR_WIDTH(4), .NUM_STAGES(3)) dut3 (
    .i_fifo_dfsync_clk     (clk),
    .i_fifo_dfsync_rst_n   (rst_n),
    .i_fifo_dfsync_gray    (gin3),
    .i_fifo_dfsync_err_clr (1'b0),
    .o_fifo_dfsync_gray    (o_gray3),
    .o_fifo_dfsync_bin     (o_bin3),
    .o_fifo_dfsync_chg     (o_chg3),
    .o_fifo_dfsync_valid   (o_valid3),
    .o_fifo_dfsync_err     (o_err3)
  );

  // Expected row packs {gray, bin, chg, err, valid}.
  typedef struct {
    int          due;
    string       name;
    logic [10:0] row;
  } exp_t;

  // One stimulus vector; bin/chg/err are the outputs three edges later.
  typedef struct packed {
    logic [3:0] gin;
    logic       clr;
    logic [3:0] bin;
    logic       chg;
    logic       err;
  } vec_t;

  exp_t sb_q [$];
  vec_t tab  [$];
  exp_t mon_e;
  int   checks   = 0;
  int   errors   = 0;
  int   edge_cnt = 0;
  int   base;
  int   n;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (gray,bin,chg,err,valid) at edge %0d",
               name, act, exp, edge_cnt);
    end
  endtask

  task automatic push(input int due, input string name, input logic [3:0] gray,
                      input logic [3:0] bin, input logic chg, input logic err, input logic vld);
    exp_t e;
    e.due  = due;
    e.name = name;
    e.row  = {gray, bin, chg, err, vld};
    sb_q.push_back(e);
  endtask

  task automatic add(input logic [3:0] g, input logic c, input logic [3:0] b, input logic ch,
                     input logic er);
    tab.push_back({g, c, b, ch, er});
  endtask

  // Monitor: compares every output row whose due edge has been reached.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= edge_cnt) begin
      mon_e = sb_q.pop_front();
      if (mon_e.due < edge_cnt) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for edge %0d missed at edge %0d", mon_e.name,
                 mon_e.due, edge_cnt);
      end else begin
        check(mon_e.name, {o_gray, o_bin, o_chg, o_err, o_valid}, mon_e.row);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations still pending, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed table, clr column aligned with the output edge it acts on.
    add(4'b0101, 1'b0, 4'b0110, 1'b0, 1'b0);  // first sample lands during warm-up
    add(4'b0100, 1'b0, 4'b0111, 1'b1, 1'b0);
    add(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    add(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0);  // first pointer step
    add(4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0);
    for (int i = 2; i < 16; i++) add(4'(i ^ (i >> 1)), 1'b0, 4'(i), 1'b1, 1'b0);
    add(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);  // wrap 1000 -> 0000
    add(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(4'b0011, 1'b0, 4'b0010, 1'b1, 1'b1);  // two-bit jump
    add(4'b0011, 1'b0, 4'b0010, 1'b0, 1'b1);
    add(4'b0011, 1'b0, 4'b0010, 1'b0, 1'b1);
    add(4'b0011, 1'b1, 4'b0010, 1'b0, 1'b0);  // clear
    add(4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0);
    add(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1);  // violation with clear: set wins
    add(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
    add(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);
    add(4'b0101, 1'b0, 4'b0110, 1'b1, 1'b1);
    add(4'b0101, 1'b0, 4'b0110, 1'b0, 1'b1);
    n = tab.size();

    // Reset with input 0101.
    #1 rst_n = 1'b0;
    #1 check("reset_async", {o_gray, o_bin, o_chg, o_err, o_valid}, 11'b0);
    repeat (3) @(negedge clk);
    check("reset_held", {o_gray, o_bin, o_chg, o_err, o_valid}, 11'b0);
    check("reset_held_ns3", {o_gray3, o_bin3, o_chg3, o_err3, o_valid3}, 11'b0);

    // Release and run the table.
    rst_n = 1'b1;
    base  = edge_cnt;
    push(base + 1, "warmup_e1", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    push(base + 2, "warmup_e2", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < n + 2; j++) begin
      if (j > 0) @(negedge clk);
      gin = tab[(j < n) ? j : n - 1].gin;
      clr = (j >= 2) ? tab[j-2].clr : 1'b0;
      if (j < n) push(edge_cnt + 3, $sformatf("row%0d", j), tab[j].gin, tab[j].bin,
                      tab[j].chg, tab[j].err, 1'b1);
    end
    @(negedge clk);
    clr = 1'b0;
    drain();

    // Reset between clock edges while the sticky error is set.
    check("pre_reset_err", {o_gray, o_bin, o_chg, o_err, o_valid}, 11'b0101_0110_0_1_1);
    #2 rst_n = 1'b0;
    #1 check("midop_reset", {o_gray, o_bin, o_chg, o_err, o_valid}, 11'b0);
    @(negedge clk);
    rst_n = 1'b1;
    base  = edge_cnt;
    push(base + 1, "rewarm_e1", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    push(base + 2, "rewarm_e2", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    push(base + 3, "rewarm_e3", 4'b0101, 4'b0110, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("ns3_valid_e3", {10'b0, o_valid3}, 11'b0);
    @(negedge clk);
    check("ns3_valid_e4", {o_gray3, o_bin3, o_chg3, o_err3, o_valid3}, 11'b0000_0000_0_0_1);

    // NUM_STAGES = 3: two-bit step reaches the output four edges later.
    gin3 = 4'b0011;
    repeat (3) @(negedge clk);
    check("ns3_e3", {o_gray3, o_bin3, o_chg3, o_err3, o_valid3}, 11'b0000_0000_0_0_1);
    @(negedge clk);
    check("ns3_e4", {o_gray3, o_bin3, o_chg3, o_err3, o_valid3}, 11'b0011_0010_1_1_1);
    @(negedge clk);
    check("ns3_e5", {o_gray3, o_bin3, o_chg3, o_err3, o_valid3}, 11'b0011_0010_0_1_1);

    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_fifo_ptr_sync.md
UART_FIFO_PTR_SYNC -- requirements
Module: uart_fifo_ptr_sync

Interface
REQ-001 The block SHALL have parameter PTR_WIDTH, default 4, meaning the Gray pointer width (FIFO address bits + 1), legal range 2..16.
REQ-002 The block SHALL have parameter NUM_STAGES, default 2, meaning the synchronizer flop depth, legal range 2..4.
REQ-003 The block SHALL have port i_fifo_dfsync_clk, input, 1 bit: destination-domain clock, rising edge.
REQ-004 The block SHALL have port i_fifo_dfsync_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port i_fifo_dfsync_gray, input, PTR_WIDTH bits: Gray-coded pointer from the source domain.
REQ-006 The block SHALL have port i_fifo_dfsync_err_clr, input, 1 bit: synchronous clear of the sticky error flag.
REQ-007 The block SHALL have port o_fifo_dfsync_gray, output, PTR_WIDTH bits: synchronized Gray pointer.
REQ-008 The block SHALL have port o_fifo_dfsync_bin, output, PTR_WIDTH bits: binary equivalent of o_fifo_dfsync_gray.
REQ-009 The block SHALL have port o_fifo_dfsync_chg, output, 1 bit: single-cycle pulse on an output pointer change.
REQ-010 The block SHALL have port o_fifo_dfsync_valid, output, 1 bit: high once the warm-up after reset has completed.
REQ-011 The block SHALL have port o_fifo_dfsync_err, output, 1 bit: sticky multi-bit-change (Gray violation) flag.

Function
REQ-012 Stage 0 SHALL sample i_fifo_dfsync_gray on every rising edge, and stage k SHALL sample stage k-1, for k = 1..NUM_STAGES-1.
REQ-013 An output register SHALL capture the last stage into o_fifo_dfsync_gray and gray-to-binary(last stage) into o_fifo_dfsync_bin on every edge, giving a total latency of NUM_STAGES+1 edges; both outputs SHALL always update together.
REQ-014 Gray-to-binary conversion SHALL be: bin[MSB] = gray[MSB]; bin[i] = bin[i+1] XOR gray[i]; no width growth.
REQ-015 o_fifo_dfsync_chg SHALL be registered and high for exactly one cycle in the cycle in which the output register takes a value different from its previous value, and only while valid = 1.
REQ-016 The block SHALL detect a Gray violation when the last stage differs from o_fifo_dfsync_gray in 2 or more bits while valid = 1; on detection, o_fifo_dfsync_err SHALL set on the next edge.
REQ-017 o_fifo_dfsync_err SHALL hold until i_fifo_dfsync_err_clr = 1 at an edge; when a violation and a clear occur in the same cycle, set SHALL win.
REQ-018 Wrap-around (e.g. Gray 1000 -> 0000 at PTR_WIDTH = 4) SHALL be a single-bit change: no error, and chg SHALL pulse.
REQ-019 A warm-up counter, ceil(log2(NUM_STAGES+2)) bits wide, SHALL count rising edges after reset release and saturate.
REQ-020 o_fifo_dfsync_valid SHALL rise at edge NUM_STAGES+1 after reset release and stay high until the next reset.
REQ-021 chg and err SHALL NOT assert while valid = 0, because the reset-to-first-sample transition is not a pointer move.

Reset
REQ-022 While i_fifo_dfsync_rst_n = 0, all stages, the output register, the counter, chg, err and valid SHALL be 0 immediately, independent of the clock.
REQ-023 A reset asserted mid-operation SHALL discard the in-flight stages and the sticky error, and warm-up SHALL restart on release.
REQ-024 Reset release SHALL be assumed synchronous to i_fifo_dfsync_clk (handled upstream); the block SHALL contain no reset synchronizer.

Structure
REQ-025 Package uart_fifo_pkg SHALL hold the gray2bin function, a popcount-based hamming function, and the NUM_STAGES legal-range constants.
REQ-026 The flop chain SHALL be sub-module uart_fifo_sync_chain (WIDTH, NUM_STAGES), instantiated once; all other logic SHALL be in the top level.
REQ-027 An elaboration-time check SHALL reject NUM_STAGES < 2 or NUM_STAGES > 4.

Verification (PTR_WIDTH = 4, NUM_STAGES = 2 unless stated)
REQ-028 Scenario, reset: hold reset, input 0101 -> all outputs 0; after release, valid = 1 at edge 3 and not before.
REQ-029 Scenario, first pointer: after warm-up, step input 0000 -> 0001 -> gray/bin = 0001/0001 three edges later, chg pulses for 1 cycle, err = 0.
REQ-030 Scenario, count and wrap: Gray count 0..15..0, one step per cycle -> bin = 0..15, 0 delayed 3 edges, chg high every cycle, err = 0 throughout.
REQ-031 Scenario, violation and clear: jump input 0000 -> 0011 -> err = 1 at edge 3 and sticky; err_clr pulse -> 0; a violation coincident with err_clr -> err stays 1.
REQ-032 Scenario, reset mid-operation: assert reset between clock edges while err = 1 -> outputs 0 with no clock edge; valid re-rises 3 edges after release.
REQ-033 Scenario, NUM_STAGES = 3: input step 0000 -> 0011 -> output latency 4 edges, valid at edge 4, err = 1.
